// File: rtl/sqrt_pkg.sv
// Shared widths and state encoding for the square-root reconstruction checker.
package sqrt_pkg;
  localparam int unsigned ROOT_W_DEF = 8;
  localparam int unsigned RAD_W_DEF  = 2 * ROOT_W_DEF;
  localparam int unsigned CNT_W_DEF  = $clog2(ROOT_W_DEF);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2,
    DONE = 2'd3
  } state_e;
endpackage

// File: rtl/sqrt_shift_add_step.sv
// One shift-add multiply step: adds mcand << idx into the accumulator when the multiplier bit is set.
module sqrt_shift_add_step
  import sqrt_pkg::*;
#(
  parameter int unsigned ROOT_W = ROOT_W_DEF,
  parameter int unsigned RAD_W  = RAD_W_DEF,
  parameter int unsigned IDX_W  = CNT_W_DEF
) (
  input  logic [RAD_W-1:0]  i_acc,
  input  logic [ROOT_W-1:0] i_mcand,
  input  logic [IDX_W-1:0]  i_idx,
  input  logic              i_bit,
  output logic [RAD_W-1:0]  o_acc
);
  logic [RAD_W-1:0] w_partial;

  assign w_partial = RAD_W'(i_mcand) << i_idx;
  assign o_acc     = i_bit ? (i_acc + w_partial) : i_acc;
endmodule

// File: rtl/sqrt_square_checker.sv
// Squares an approximate root by iterative shift-add and reports radicand - root^2 with
// overshoot/exact flags; valid/ready on both sides, one transaction in flight.
module sqrt_square_checker
  import sqrt_pkg::*;
#(
  parameter int unsigned ROOT_W = ROOT_W_DEF,
  parameter int unsigned RAD_W  = RAD_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ROOT_W-1:0] root,
  input  logic [RAD_W-1:0]  radicand,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [RAD_W-1:0]  square,
  output logic [RAD_W:0]    residual,
  output logic              over,
  output logic              exact,
  output logic              busy
);
  localparam int unsigned CNT_W = (ROOT_W > 1) ? $clog2(ROOT_W) : 1;

  state_e            r_state;
  logic [ROOT_W-1:0] r_mcand;
  logic [ROOT_W-1:0] r_mplier;
  logic [RAD_W-1:0]  r_rad;
  logic [RAD_W-1:0]  r_acc;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_in_ready;
  logic              r_out_valid;
  logic [RAD_W-1:0]  r_square;
  logic [RAD_W:0]    r_residual;
  logic              r_over;
  logic              r_exact;

  logic [RAD_W-1:0]  w_acc_next;
  logic [RAD_W:0]    w_residual;

  // Zero-extended subtraction: the top bit is the sign, set exactly on overshoot.
  assign w_residual = {1'b0, r_rad} - {1'b0, r_acc};

  sqrt_shift_add_step #(
    .ROOT_W (ROOT_W),
    .RAD_W  (RAD_W),
    .IDX_W  (CNT_W)
  ) u_step (
    .i_acc   (r_acc),
    .i_mcand (r_mcand),
    .i_idx   (r_cnt),
    .i_bit   (r_mplier[r_cnt]),
    .o_acc   (w_acc_next)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_mcand     <= '0;
      r_mplier    <= '0;
      r_rad       <= '0;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_square    <= '0;
      r_residual  <= '0;
      r_over      <= 1'b0;
      r_exact     <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (in_valid && r_in_ready) begin
            r_mcand    <= root;
            r_mplier   <= root;
            r_rad      <= radicand;
            r_acc      <= '0;
            r_cnt      <= '0;
            r_in_ready <= 1'b0;
            r_state    <= CALC;
          end else begin
            r_in_ready <= 1'b1;
          end
        end
        CALC: begin
          r_acc <= w_acc_next;
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == CNT_W'(ROOT_W - 1)) begin
            r_state <= FIN;
          end
        end
        FIN: begin
          r_square    <= r_acc;
          r_residual  <= w_residual;
          r_over      <= w_residual[RAD_W];
          r_exact     <= (w_residual == '0);
          r_out_valid <= 1'b1;
          r_state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign square    = r_square;
  assign residual  = r_residual;
  assign over      = r_over;
  assign exact     = r_exact;
  assign busy      = (r_state != IDLE);
endmodule

// File: tb/tb_sqrt_square_checker.sv
// Scoreboard bench for sqrt_square_checker: expectations queued at drive time, checked at output handshake.
module tb_sqrt_square_checker;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [7:0]  root = '0;
  logic [15:0] radicand = '0;
  logic        in_ready;
  logic        out_valid;
  logic [15:0] square;
  logic [16:0] residual;
  logic        over;
  logic        exact;
  logic        busy;

  typedef struct {
    logic [15:0] sq;
    logic [16:0] res;
    logic        ov;
    logic        ex;
  } exp_t;

  exp_t sb[$];
  int unsigned total = 0;
  int unsigned bad = 0;
  int cyc = 0;
  int acc_cyc = -100;
  int hs_cyc = -100;
  logic prev_ov = 1'b0;

  sqrt_square_checker #(
    .ROOT_W (8),
    .RAD_W  (16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .root      (root),
    .radicand  (radicand),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .square    (square),
    .residual  (residual),
    .over      (over),
    .exact     (exact),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (rst_n && in_valid && in_ready) acc_cyc = cyc;
    if (rst_n && out_valid && out_ready) hs_cyc = cyc;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic exp_t mk_exp(input logic [7:0] r, input logic [15:0] d);
    exp_t e;
    int sqv;
    int rv;
    sqv   = int'(r) * int'(r);
    rv    = int'(d) - sqv;
    e.sq  = sqv[15:0];
    e.res = rv[16:0];
    e.ov  = (rv < 0);
    e.ex  = (rv == 0);
    return e;
  endfunction

  // Output monitor: samples just after the falling edge, once all bench drives have settled.
  always begin
    exp_t e;
    @(negedge clk);
    #1;
    if (out_valid && !prev_ov) check_eq("latency", 32'(cyc - acc_cyc), 32'd9);
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check_eq("unexpected_out", 32'(out_valid), 32'd0);
      end else begin
        e = sb.pop_front();
        check_eq("square", 32'(square), 32'(e.sq));
        check_eq("residual", 32'(residual), 32'(e.res));
        check_eq("over", 32'(over), 32'(e.ov));
        check_eq("exact", 32'(exact), 32'(e.ex));
      end
    end
    prev_ov = out_valid;
  end

  task automatic send(input logic [7:0] r, input logic [15:0] d, input bit push);
    int n = 0;
    root     = r;
    radicand = d;
    in_valid = 1'b1;
    if (push) sb.push_back(mk_exp(r, d));
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check_eq("accept_timeout", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) check_eq("drain_timeout", 32'(sb.size()), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    check_eq("rst_in_ready", 32'(in_ready), 32'd0);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_square", 32'(square), 32'd0);
    check_eq("rst_residual", 32'(residual), 32'd0);
    check_eq("rst_over", 32'(over), 32'd0);
    check_eq("rst_exact", 32'(exact), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rdy_after_rst", 32'(in_ready), 32'd1);

    send(8'd0, 16'd0, 1'b1);
    send(8'd255, 16'd65535, 1'b1);
    send(8'd16, 16'd255, 1'b1);
    drain();

    // Backpressure: result held while a new pair waits at the input.
    out_ready = 1'b0;
    send(8'd12, 16'd150, 1'b1);
    root     = 8'd99;
    radicand = 16'd9000;
    in_valid = 1'b1;
    sb.push_back(mk_exp(8'd99, 16'd9000));
    n = 0;
    while (!out_valid && n < 30) begin
      @(negedge clk);
      n++;
    end
    check_eq("bp_out_valid", 32'(out_valid), 32'd1);
    for (int k = 0; k < 5; k++) begin
      check_eq("bp_square", 32'(square), 32'd144);
      check_eq("bp_residual", 32'(residual), 32'd6);
      check_eq("bp_in_ready", 32'(in_ready), 32'd0);
      check_eq("bp_hold_valid", 32'(out_valid), 32'd1);
      @(negedge clk);
    end
    out_ready = 1'b1;
    n = 0;
    while (!in_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    check_eq("bp_ready_back", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    check_eq("bp_accept_gap", 32'(acc_cyc - hs_cyc), 32'd1);
    drain();

    // Reset on the 4th CALC cycle discards the transaction; in_valid during reset is ignored.
    send(8'd200, 16'd40000, 1'b0);
    repeat (3) @(negedge clk);
    check_eq("calc_busy", 32'(busy), 32'd1);
    rst_n    = 1'b0;
    in_valid = 1'b1;
    root     = 8'd77;
    radicand = 16'd5;
    repeat (2) begin
      @(negedge clk);
      check_eq("mid_rst_in_ready", 32'(in_ready), 32'd0);
      check_eq("mid_rst_out_valid", 32'(out_valid), 32'd0);
      check_eq("mid_rst_busy", 32'(busy), 32'd0);
    end
    in_valid = 1'b0;
    rst_n    = 1'b1;
    @(negedge clk);
    check_eq("rdy_after_mid_rst", 32'(in_ready), 32'd1);
    repeat (15) begin
      @(negedge clk);
      check_eq("no_stale_out", 32'(out_valid), 32'd0);
    end
    send(8'd3, 16'd10, 1'b1);
    drain();

    // Sweep every root with a random radicand and the exact / one-below boundaries.
    for (int r = 0; r < 256; r++) begin
      send(8'(r), 16'($urandom), 1'b1);
      send(8'(r), 16'(r * r), 1'b1);
      if (r > 0) send(8'(r), 16'(r * r - 1), 1'b1);
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sqrt_square_checker.md
Name: sqrt_square_checker

Overview:
- Sequential inverse of the approximate square-root datapath: takes an 8-bit root and its 16-bit radicand, squares the root with an iterative shift-add, and reports the reconstruction residual (radicand - root^2).
- Sits downstream of the square-root unit in the Sobel-magnitude path, where it grades approximation error and flags overshoot.
- Valid/ready on input and output; one transaction in flight.

Parameters:
- ROOT_W, 8, root width; also the number of shift-add iterations.
- RAD_W, 16, radicand/square width; must equal 2*ROOT_W.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  reset; synchronous, active-low
- in_valid  input  1  root/radicand pair valid
- in_ready  output  1  block can accept a pair
- root  input  ROOT_W  approximate root under test
- radicand  input  RAD_W  original radicand
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- square  output  RAD_W  root*root, exact
- residual  output  RAD_W+1  radicand - square, two's complement
- over  output  1  square > radicand (residual sign bit)
- exact  output  1  residual == 0
- busy  output  1  state != IDLE

Behaviour:
- Single clock. Reset is synchronous and active-low: all registers update only on the rising edge of clk while rst_n = 0.
- Reset values: in_ready=0, out_valid=0, square=0, residual=0, over=0, exact=0, busy=0. State goes to IDLE.
- in_ready is registered. It is 1 in IDLE from the first edge after rst_n rises.
- FSM states and transitions:
  - IDLE -> CALC on in_valid && in_ready. That edge is the accept edge.
    - Latch root into mcand and mplier. Latch radicand.
    - Clear the accumulator and the iteration count. Drop in_ready.
  - CALC runs ROOT_W cycles, one edge per bit i = 0..ROOT_W-1, LSB first.
    - If mplier[i]: acc += mcand << i. Width is RAD_W; no overflow, since max 255^2 = 65025.
    - Leave CALC after the edge that processes i = ROOT_W-1.
  - FIN, one cycle:
    - Register square = acc.
    - Register residual = {1'b0,radicand} - {1'b0,acc}.
    - Register over = residual[RAD_W] and exact = (residual == 0).
    - Set out_valid. Go to DONE.
  - DONE: hold all outputs stable while out_valid && !out_ready.
    - On out_valid && out_ready: clear out_valid, go to IDLE, set in_ready.
    - Output fields keep their last values until overwritten.
- Latency: out_valid is visible after exactly ROOT_W+1 edges following the accept edge (9 for defaults). It is independent of the data; there is no early exit on a zero root.
- Throughput: at best one result per ROOT_W+3 cycles. The input is never accepted in the same cycle as the output handshake.
- in_valid while in_ready=0 is ignored. root and radicand are sampled only on the accept edge.
- Reset mid-operation: the in-flight transaction is discarded; out_valid never rises for it. Reset values apply at the next edge.
- rst_n low and in_valid high in the same cycle: nothing is accepted.
- Residual range is -65025..+65535. over=1 exactly when the root overshoots.

Decomposition:
- Package sqrt_pkg:
  - ROOT_W and RAD_W defaults.
  - State enum {IDLE, CALC, FIN, DONE}.
  - Iteration-count width $clog2(ROOT_W).
- Sub-module sqrt_shift_add_step (combinational): inputs acc, mcand, bit index, mplier bit; output next acc. Instantiated once in the CALC datapath.
- The FSM and handshake logic live in the top module.

Test Plan:
- Reset, then root=0, radicand=0 -> out_valid 9 edges after accept; square=0, residual=17'h00000, exact=1, over=0.
- root=255, radicand=65535 -> square=65025 (16'hFE01), residual=+510 (17'h001FE), over=0, exact=0.
- root=16, radicand=255 -> square=256, residual=-1 (17'h1FFFF), over=1, exact=0.
- Backpressure:
  - Stimulus: root=12, radicand=150; hold out_ready=0 for 5 cycles after out_valid; keep in_valid=1 with root=99.
  - Required: outputs stable at square=144, residual=6. in_ready=0 throughout; root=99 is not accepted until the cycle after the output handshake.
- Reset mid-operation:
  - Stimulus: drop rst_n on the 4th CALC cycle of root=200, then release; next send root=3, radicand=10.
  - Required: no out_valid for root=200; in_ready=0 during reset. The second transaction gives square=9, residual=1.
- Sweep: all 256 roots paired with random radicands, plus radicand=root^2 and root^2-1 -> every result matches a scoreboard model; exact and over flags are correct at each boundary.
